pc_next_ctrl: RTL
=================

PC_NEXT_CTRL -- requirements
Module: pc_next_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port instr_valid  input  1  instruction at pc_o is present in decode this cycle.
REQ-005 SHALL have port stall  input  1  hold PC and state; no resolution this cycle.
REQ-006 SHALL have port opcode  input  7  opcode of the instruction at pc_o.
REQ-007 SHALL have port funct3  input  3  funct3 of the instruction at pc_o.
REQ-008 SHALL have port BrEq  input  1  branch comparator equal flag.
REQ-009 SHALL have port BrLT  input  1  branch comparator less-than flag, signedness already selected by funct3[2:1].
REQ-010 SHALL have port imm  input  32  sign-extended B/J/I immediate.
REQ-011 SHALL have port rs1_data  input  32  rs1 value, used by JALR.
REQ-012 SHALL have port cnt_clr  input  1  synchronous clear of the performance counters.
REQ-013 SHALL have port pc_o  output  32  registered current PC.
REQ-014 SHALL have port pc_plus4  output  32  combinational pc_o+4, the link value.
REQ-015 SHALL have port PCSel  output  1  combinational; 1 = redirect to target.
REQ-016 SHALL have port flush  output  1  registered one-cycle squash of the wrong-path instruction.
REQ-017 SHALL have port misalign_trap  output  1  sticky misaligned-target trap.
REQ-018 SHALL have port trap_addr  output  32  target captured at the trap.
REQ-019 SHALL have ports br_cnt and taken_cnt  output  16 each  resolved-branch count and taken-branch count.

Function
REQ-020 SHALL define resolve = (state==RUN) & instr_valid & ~stall.
REQ-021 SHALL decode B-type (7'b1100011) taken as follows: 000 BrEq; 001 ~BrEq; 100 BrLT; 101 ~BrLT; 110 BrLT; 111 ~BrLT.
REQ-022 SHALL treat B-type funct3 010 and 011 as not taken and not counted.
REQ-023 SHALL treat JAL (7'b1101111) as always taken with target = pc_o + imm, modulo 2^32.
REQ-024 SHALL treat JALR (7'b1100111) as always taken with target = (rs1_data + imm) & ~32'h1, modulo 2^32.
REQ-025 SHALL drive PCSel = taken & instr_valid & (state==RUN), independent of stall; PCSel = 0 in FLUSH and TRAP.
REQ-026 SHALL implement the states: RUN, FLUSH, TRAP.
REQ-027 SHALL, on resolve with taken and aligned target (target[1:0]==0): load pc_o with target next edge and go to FLUSH.
REQ-028 SHALL, on resolve with not taken: load pc_o with pc_o+4 and stay in RUN.
REQ-029 SHALL, in RUN with ~resolve, hold pc_o.
REQ-030 SHALL assert flush exactly while state==FLUSH.
REQ-031 SHALL stay in FLUSH exactly one cycle regardless of stall or instr_valid, holding pc_o, then go to RUN.
REQ-032 SHALL, on resolve with taken and target[1:0]!=0: hold pc_o, set misalign_trap, capture trap_addr=target, not assert flush, and go to TRAP.
REQ-033 SHALL keep TRAP until reset, with pc_o frozen and counters still clearable by cnt_clr.
REQ-034 SHALL increment br_cnt on each resolve of a legal B-type instruction.
REQ-035 SHALL increment taken_cnt on each resolve of a legal taken B-type instruction; JAL/JALR are not counted.
REQ-036 SHALL saturate both counters at 16'hFFFF.
REQ-037 SHALL give cnt_clr priority over a simultaneous increment, so the counter becomes 0.
REQ-038 SHALL count a misaligned taken branch in both counters.
REQ-039 SHALL treat a wrap of pc_o+4 past 32'hFFFF_FFFC as modulo 2^32 (result 0), with no trap.

Reset
REQ-040 SHALL, while rst_n=0 (asynchronously, including mid-FLUSH or in TRAP), force pc_o=RESET_PC, state=RUN, flush=0, misalign_trap=0, trap_addr=0, br_cnt=0, taken_cnt=0.
REQ-041 SHALL make its first resolution possible on the first rising edge after rst_n deasserts.

Verification
REQ-042 SHALL cover: pc_o=0x100, BEQ, BrEq=1, imm=0x20 -> PCSel=1; next cycle pc_o=0x120, flush=1; following cycle flush=0; br_cnt=1, taken_cnt=1.
REQ-043 SHALL cover: pc_o=0x100, BGEU, BrLT=1 -> PCSel=0; pc_o=0x104, flush never asserted; br_cnt=1, taken_cnt=0.
REQ-044 SHALL cover: JALR with rs1_data=0x1003, imm=0 -> target 0x1002; misalign_trap=1, trap_addr=0x1002, pc_o held; later stimulus has no effect until rst_n pulse.
REQ-045 SHALL cover: taken BNE with stall=1 for 3 cycles -> PCSel=1 and pc_o held; on stall release, single redirect and counters +1 only.
REQ-046 SHALL cover: br_cnt preloaded to 0xFFFF by 65535 resolved branches, one more branch -> stays 0xFFFF; cnt_clr with a simultaneous branch -> 0.
REQ-047 SHALL cover: rst_n low mid-FLUSH -> flush=0 and pc_o=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_next_ctrl.sv
// rtl/pc_next_ctrl.sv - next-PC selection, branch resolution, flush/trap sequencing and branch counters
module pc_next_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        BrEq,
    input  logic        BrLT,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        cnt_clr,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4,
    output logic        PCSel,
    output logic        flush,
    output logic        misalign_trap,
    output logic [31:0] trap_addr,
    output logic [15:0] br_cnt,
    output logic [15:0] taken_cnt
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_flush;
    logic        r_misalign;
    logic [31:0] r_trap_addr;
    logic [15:0] r_br_cnt;
    logic [15:0] r_taken_cnt;

    logic        w_is_branch;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_br_legal;
    logic        w_br_cond;
    logic        w_taken;
    logic        w_run;
    logic        w_resolve;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_misalign;
    logic        w_trap_set;
    logic        w_inc_br;
    logic        w_inc_taken;

    assign w_is_branch = (opcode == OPC_BRANCH);
    assign w_is_jal    = (opcode == OPC_JAL);
    assign w_is_jalr   = (opcode == OPC_JALR);
    // funct3 010/011 are reserved encodings: never taken, never counted
    assign w_br_legal  = w_is_branch & (funct3[2:1] != 2'b01);

    // Branch condition from the comparator flags; BrLT already carries signedness
    always_comb begin
        w_br_cond = 1'b0;
        case (funct3)
            3'b000:         w_br_cond = BrEq;
            3'b001:         w_br_cond = ~BrEq;
            3'b100, 3'b110: w_br_cond = BrLT;
            3'b101, 3'b111: w_br_cond = ~BrLT;
            default:        w_br_cond = 1'b0;
        endcase
    end

    assign w_taken    = (w_br_legal & w_br_cond) | w_is_jal | w_is_jalr;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_target   = w_is_jalr ? ((rs1_data + imm) & ~32'h1) : (r_pc + imm);
    assign w_misalign = (w_target[1:0] != 2'b00);
    assign w_run      = (r_state == ST_RUN);
    assign w_resolve  = w_run & instr_valid & ~stall;

    // Next state and next PC; only a resolving instruction in RUN moves the PC
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_trap_set  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_resolve) begin
                    if (w_taken) begin
                        if (w_misalign) begin
                            w_state_nxt = ST_TRAP;
                            w_trap_set  = 1'b1;
                        end else begin
                            w_pc_nxt    = w_target;
                            w_state_nxt = ST_FLUSH;
                        end
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
            end
            ST_FLUSH: w_state_nxt = ST_RUN;
            ST_TRAP:  w_state_nxt = ST_TRAP;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // State, PC, flush and trap capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_flush     <= 1'b0;
            r_misalign  <= 1'b0;
            r_trap_addr <= 32'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_flush    <= (w_state_nxt == ST_FLUSH);
            r_misalign <= r_misalign | w_trap_set;
            if (w_trap_set) begin
                r_trap_addr <= w_target;
            end
        end
    end

    assign w_inc_br    = w_resolve & w_br_legal;
    assign w_inc_taken = w_inc_br & w_br_cond;

    // Saturating branch counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt    <= 16'h0;
            r_taken_cnt <= 16'h0;
        end else if (cnt_clr) begin
            r_br_cnt    <= 16'h0;
            r_taken_cnt <= 16'h0;
        end else begin
            if (w_inc_br && (r_br_cnt != 16'hFFFF)) begin
                r_br_cnt <= r_br_cnt + 16'd1;
            end
            if (w_inc_taken && (r_taken_cnt != 16'hFFFF)) begin
                r_taken_cnt <= r_taken_cnt + 16'd1;
            end
        end
    end

    assign pc_o          = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign PCSel         = w_taken & instr_valid & w_run;
    assign flush         = r_flush;
    assign misalign_trap = r_misalign;
    assign trap_addr     = r_trap_addr;
    assign br_cnt        = r_br_cnt;
    assign taken_cnt     = r_taken_cnt;

endmodule
